// File: rtl/timer_counter_core_if.sv
// Bus bundle between the timer register layer (master) and the counting core (slave).
// Compare-match signals exist only when TMR_CMP_EN is defined.
interface timer_counter_core_if #(
  parameter int unsigned WIDTH = 8
);
  logic             clk_ena;
  logic             tmr_en;
  logic             cnt_dn;
  logic             load;
  logic [WIDTH-1:0] tdr;
  logic             ovf_clr;
  logic             udf_clr;
  logic [WIDTH-1:0] cnt;
  logic             ovf_flag;
  logic             udf_flag;
  logic             running;
`ifdef TMR_CMP_EN
  logic [WIDTH-1:0] cmp_val;
  logic             cmp_clr;
  logic             cmp_flag;
`endif

  modport master (
    output clk_ena, tmr_en, cnt_dn, load, tdr, ovf_clr, udf_clr,
`ifdef TMR_CMP_EN
    output cmp_val, cmp_clr,
    input  cmp_flag,
`endif
    input  cnt, ovf_flag, udf_flag, running
  );

  modport slave (
    input  clk_ena, tmr_en, cnt_dn, load, tdr, ovf_clr, udf_clr,
`ifdef TMR_CMP_EN
    input  cmp_val, cmp_clr,
    output cmp_flag,
`endif
    output cnt, ovf_flag, udf_flag, running
  );
endinterface

// File: rtl/timer_counter_core.sv
// Timer counting stage: up/down counter advanced by clk_ena ticks, with load, wrap/auto-reload,
// sticky ovf/udf flags. Optional compare-match flag when the TMR_CMP_EN macro is defined.
module timer_counter_core #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned AUTO_RELOAD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  timer_counter_core_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StArm, StRun} state_e;

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  state_e           state_q;
  logic             running_q;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             cnt_evt;
  logic             ovf_set, udf_set;

  // ARM exists only to swallow a tick that coincides with enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      running_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.tmr_en) state_q <= StArm;
        end
        StArm: begin
          if (bus.tmr_en) begin
            state_q   <= StRun;
            running_q <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          if (!bus.tmr_en) begin
            state_q   <= StIdle;
            running_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_evt = (state_q == StRun) && bus.clk_ena;

  always_comb begin
    cnt_d   = cnt_q;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    if (bus.load) begin
      cnt_d = bus.tdr;
    end else if (cnt_evt) begin
      if (!bus.cnt_dn) begin
        if (cnt_q == '1) begin
          ovf_set = 1'b1;
          cnt_d   = (AUTO_RELOAD != 0) ? bus.tdr : '0;
        end else begin
          cnt_d = cnt_q + One;
        end
      end else begin
        if (cnt_q == '0) begin
          udf_set = 1'b1;
          cnt_d   = (AUTO_RELOAD != 0) ? bus.tdr : '1;
        end else begin
          cnt_d = cnt_q - One;
        end
      end
    end
    // Set has priority over a coincident clear.
    ovf_d = ovf_set | (ovf_q & ~bus.ovf_clr);
    udf_d = udf_set | (udf_q & ~bus.udf_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign bus.cnt      = cnt_q;
  assign bus.ovf_flag = ovf_q;
  assign bus.udf_flag = udf_q;
  assign bus.running  = running_q;

`ifdef TMR_CMP_EN
  logic cmp_q, cmp_d;

  always_comb begin
    cmp_d = cmp_q & ~bus.cmp_clr;
    if ((bus.load || cnt_evt) && (cnt_d == bus.cmp_val)) cmp_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmp_q <= 1'b0;
    end else begin
      cmp_q <= cmp_d;
    end
  end

  assign bus.cmp_flag = cmp_q;
`endif

endmodule

// File: tb/tb_timer_counter_core.sv
// Self-checking bench: plain-wrap and auto-reload cores driven in parallel, checked every cycle
// against an integer reference model, with directed scenarios followed by random traffic.
module tb_timer_counter_core;
  localparam int unsigned W   = 8;
  localparam int          Max = 255;

  logic       clk = 1'b0;
  logic       rst_n, tmr_en, clk_ena, cnt_dn, load, ovf_clr, udf_clr, cmp_clr;
  logic [7:0] tdr, cmp_val;

  always #5 clk = ~clk;

  timer_counter_core_if #(.WIDTH(W)) bus0 ();
  timer_counter_core_if #(.WIDTH(W)) bus1 ();

  assign bus0.clk_ena = clk_ena;
  assign bus0.tmr_en  = tmr_en;
  assign bus0.cnt_dn  = cnt_dn;
  assign bus0.load    = load;
  assign bus0.tdr     = tdr;
  assign bus0.ovf_clr = ovf_clr;
  assign bus0.udf_clr = udf_clr;
  assign bus1.clk_ena = clk_ena;
  assign bus1.tmr_en  = tmr_en;
  assign bus1.cnt_dn  = cnt_dn;
  assign bus1.load    = load;
  assign bus1.tdr     = tdr;
  assign bus1.ovf_clr = ovf_clr;
  assign bus1.udf_clr = udf_clr;
`ifdef TMR_CMP_EN
  assign bus0.cmp_val = cmp_val;
  assign bus0.cmp_clr = cmp_clr;
  assign bus1.cmp_val = cmp_val;
  assign bus1.cmp_clr = cmp_clr;
`endif

  timer_counter_core #(.WIDTH(W), .AUTO_RELOAD(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  timer_counter_core #(.WIDTH(W), .AUTO_RELOAD(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int checks = 0;
  int errors = 0;

  // Reference state: index 0 = plain wrap, 1 = auto-reload.
  int m_cnt[2];
  int m_ovf[2];
  int m_udf[2];
  int m_cmp[2];
  int en_streak;  // consecutive sampled edges with tmr_en=1 since reset/disable

  task automatic check_eq(string tag, int unsigned got, int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int nxt;
    bit o, u, evt;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] = 0; m_ovf[k] = 0; m_udf[k] = 0; m_cmp[k] = 0;
      end
      en_streak = 0;
    end else begin
      // Counting only once enable has been seen on two consecutive edges.
      evt = (en_streak >= 2) && clk_ena;
      for (int k = 0; k < 2; k++) begin
        nxt = m_cnt[k];
        o = 1'b0;
        u = 1'b0;
        if (load) begin
          nxt = int'(tdr);
        end else if (evt) begin
          if (!cnt_dn) begin
            nxt = m_cnt[k] + 1;
            if (nxt > Max) begin
              o = 1'b1;
              nxt = (k == 1) ? int'(tdr) : nxt - (Max + 1);
            end
          end else begin
            nxt = m_cnt[k] - 1;
            if (nxt < 0) begin
              u = 1'b1;
              nxt = (k == 1) ? int'(tdr) : nxt + (Max + 1);
            end
          end
        end
        m_ovf[k] = o ? 1 : (ovf_clr ? 0 : m_ovf[k]);
        m_udf[k] = u ? 1 : (udf_clr ? 0 : m_udf[k]);
        m_cmp[k] = ((load || evt) && nxt == int'(cmp_val)) ? 1 : (cmp_clr ? 0 : m_cmp[k]);
        m_cnt[k] = nxt;
      end
      en_streak = tmr_en ? ((en_streak < 2) ? en_streak + 1 : 2) : 0;
    end
  endtask

  task automatic compare_all();
    check_eq("cnt0", bus0.cnt, m_cnt[0]);
    check_eq("ovf0", bus0.ovf_flag, m_ovf[0]);
    check_eq("udf0", bus0.udf_flag, m_udf[0]);
    check_eq("run0", bus0.running, (en_streak >= 2) ? 1 : 0);
    check_eq("cnt1", bus1.cnt, m_cnt[1]);
    check_eq("ovf1", bus1.ovf_flag, m_ovf[1]);
    check_eq("udf1", bus1.udf_flag, m_udf[1]);
    check_eq("run1", bus1.running, (en_streak >= 2) ? 1 : 0);
`ifdef TMR_CMP_EN
    check_eq("cmp0", bus0.cmp_flag, m_cmp[0]);
    check_eq("cmp1", bus1.cmp_flag, m_cmp[1]);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse_load(input logic [7:0] val);
    tdr  = val;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tmr_en = 1'b1; clk_ena = 1'b1; cnt_dn = 1'b0; load = 1'b0;
    tdr = 8'h00; ovf_clr = 1'b0; udf_clr = 1'b0; cmp_clr = 1'b0; cmp_val = 8'hA5;
    for (int i = 0; i < 4; i++) m_cnt[i % 2] = 0;
    en_streak = 0;

    // Reset held against active enable and ticks.
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rst_cnt", bus0.cnt, 0);
      check_eq("rst_run", bus0.running, 0);
    end

    // Up count through the wrap, one tick every 4 clocks.
    rst_n = 1'b1; tmr_en = 1'b0; clk_ena = 1'b0;
    pulse_load(8'hFD);
    tmr_en = 1'b1;
    step();
    step();
    check_eq("wrap_start", bus0.cnt, 8'hFD);
    for (int t = 0; t < 3; t++) begin
      clk_ena = 1'b1;
      step();
      clk_ena = 1'b0;
      for (int g = 0; g < 3; g++) step();
    end
    check_eq("wrap_cnt", bus0.cnt, 8'h00);
    check_eq("wrap_ovf", bus0.ovf_flag, 1);
    check_eq("wrap_udf", bus0.udf_flag, 0);
    check_eq("reload_up_cnt", bus1.cnt, 8'hFD);

    // Down count through zero.
    ovf_clr = 1'b1; udf_clr = 1'b1;
    step();
    ovf_clr = 1'b0; udf_clr = 1'b0;
    pulse_load(8'h05);
    cnt_dn = 1'b1; clk_ena = 1'b1;
    for (int t = 0; t < 4; t++) step();
    check_eq("dn_at_01", bus1.cnt, 8'h01);
    step();
    check_eq("dn_at_00", bus1.cnt, 8'h00);
    step();
    check_eq("reload_dn_cnt", bus1.cnt, 8'h05);
    check_eq("reload_dn_udf", bus1.udf_flag, 1);
    check_eq("wrap_dn_cnt", bus0.cnt, 8'hFF);
    clk_ena = 1'b0;

    // Load beats a coincident tick; no flag from that tick.
    ovf_clr = 1'b1; udf_clr = 1'b1;
    step();
    ovf_clr = 1'b0; udf_clr = 1'b0; cnt_dn = 1'b0;
    pulse_load(8'hFF);
    clk_ena = 1'b1;
    pulse_load(8'h40);
    clk_ena = 1'b0;
    check_eq("coll_load_cnt", bus0.cnt, 8'h40);
    check_eq("coll_load_ovf", bus0.ovf_flag, 0);

    // Overflow set beats a coincident clear.
    pulse_load(8'hFF);
    clk_ena = 1'b1;
    step();
    clk_ena = 1'b0;
    pulse_load(8'hFF);
    clk_ena = 1'b1; ovf_clr = 1'b1;
    step();
    clk_ena = 1'b0;
    check_eq("coll_clr_ovf", bus0.ovf_flag, 1);
    step();
    check_eq("clr_alone_ovf", bus0.ovf_flag, 0);
    ovf_clr = 1'b0;

    // Enable timing with a tick every cycle.
    tmr_en = 1'b0;
    step();
    step();
    pulse_load(8'h10);
    clk_ena = 1'b1; tmr_en = 1'b1;
    step();
    check_eq("en_arm_cnt", bus0.cnt, 8'h10);
    check_eq("en_arm_run", bus0.running, 0);
    step();
    check_eq("en_run_cnt", bus0.cnt, 8'h10);
    check_eq("en_run_run", bus0.running, 1);
    step();
    check_eq("en_inc1", bus0.cnt, 8'h11);
    step();
    check_eq("en_inc2", bus0.cnt, 8'h12);
    tmr_en = 1'b0;
    step();
    check_eq("dis_last", bus0.cnt, 8'h13);
    step();
    check_eq("dis_frozen", bus0.cnt, 8'h13);
    check_eq("dis_run", bus0.running, 0);
    clk_ena = 1'b0;

`ifdef TMR_CMP_EN
    cmp_val = 8'h10;
    pulse_load(8'h0E);
    cmp_clr = 1'b1;
    step();
    cmp_clr = 1'b0; tmr_en = 1'b1;
    step();
    step();
    clk_ena = 1'b1;
    step();
    check_eq("cmp_before", bus0.cmp_flag, 0);
    step();
    check_eq("cmp_hit", bus0.cmp_flag, 1);
    clk_ena = 1'b0; cmp_clr = 1'b1;
    step();
    check_eq("cmp_cleared", bus0.cmp_flag, 0);
    cmp_clr = 1'b0; clk_ena = 1'b1;
    step();
    check_eq("cmp_at_11", bus0.cmp_flag, 0);
    clk_ena = 1'b0;
`endif

    // Random traffic biased toward wrap boundaries.
    for (int i = 0; i < 3000; i++) begin
      rst_n   = ($urandom_range(63) != 0);
      tmr_en  = ($urandom_range(7) != 0);
      clk_ena = 1'($urandom_range(1));
      cnt_dn  = ($urandom_range(15) == 0) ? ~cnt_dn : cnt_dn;
      load    = ($urandom_range(15) == 0);
      case ($urandom_range(4))
        0:       tdr = 8'h00;
        1:       tdr = 8'hFF;
        2:       tdr = 8'h01;
        3:       tdr = 8'hFE;
        default: tdr = 8'($urandom);
      endcase
      cmp_val = 8'($urandom_range(3)) + 8'hFE;
      ovf_clr = ($urandom_range(7) == 0);
      udf_clr = ($urandom_range(7) == 0);
      cmp_clr = ($urandom_range(7) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
